alu_seq_ctrl: RTL and testbench

Multi-cycle control sequencer for the single-ported register-file/ALU/data-memory datapath. It accepts one 32-bit RV32I instruction at a time over a valid/ready handshake and decodes it. It then walks the datapath through DECODE, EXEC, optional MEM and WB cycles, driving the datapath's control inputs: register addresses, ALU select/control, immediate, result select and write enable. Branch decisions come from the datapath's EQ flag and are reported to the fetch side as a one-cycle redirect pulse.

---
 rtl/alu_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Purpose : multi-cycle RV32I control sequencer for the register-file/ALU/data-memory datapath.
// Latency : handshake at T -> ALU ready T+4, lw ready T+5, branch ready T+3, illegal ready T+2.
// Backpressure: instr_ready is high only in IDLE; instr_valid is ignored while an instruction runs.
//
// Ports: clk/rst (async active-high) | instr_valid/instr/instr_ready accept one instruction
//        EQ from the datapath | RegWrite, ALUsrc, ALUctrl, immOp, Resultsrc, rs1, rs2, rd drive the datapath
//        pc_src/branch_off redirect fetch | retire/illegal status pulses | instret retired count
// Optional feature: define ALU_SEQ_PERF_CNT_EN to build the instret counter (otherwise tied to 0).
module alu_seq_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    input  logic [DATA_WIDTH-1:0]    instr,
    output logic                     instr_ready,
    input  logic                     EQ,
    output logic                     RegWrite,
    output logic                     ALUsrc,
    output logic [2:0]               ALUctrl,
    output logic [DATA_WIDTH-1:0]    immOp,
    output logic                     Resultsrc,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic                     pc_src,
    output logic [DATA_WIDTH-1:0]    branch_off,
    output logic                     retire,
    output logic                     illegal,
    output logic [31:0]              instret
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [1:0] {K_ALU, K_LW, K_BR} kind_t;

    state_t r_state, w_next;

    // Registered instruction class and datapath fields, loaded on DECODE entry
    kind_t                  r_kind;
    logic                   r_bne;
    logic                   r_illegal;
    logic                   r_alusrc;
    logic [2:0]             r_aluctrl;
    logic [DATA_WIDTH-1:0]  r_imm;
    logic [DATA_WIDTH-1:0]  r_boff;
    logic                   r_resultsrc;
    logic [ADDRESS_WIDTH-1:0] r_rs1, r_rs2, r_rd;

    // Combinational decode of the offered instruction word
    logic [6:0] w_opcode, w_funct7;
    logic [2:0] w_funct3;
    logic       w_legal, w_src, w_bne, w_use_rs2, w_use_rd, w_use_imm;
    logic [2:0] w_alu;
    kind_t      w_kind;
    logic       w_accept;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_accept = (r_state == S_IDLE) && instr_valid;

    always_comb begin
        w_legal   = 1'b0;
        w_kind    = K_ALU;
        w_alu     = 3'b000;
        w_src     = 1'b0;
        w_bne     = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_use_imm = 1'b0;
        case (w_opcode)
            7'b0110011: begin
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
                case ({w_funct7, w_funct3})
                    {7'h00, 3'b000}: begin w_legal = 1'b1; w_alu = 3'b000; end
                    {7'h20, 3'b000}: begin w_legal = 1'b1; w_alu = 3'b001; end
                    {7'h00, 3'b111}: begin w_legal = 1'b1; w_alu = 3'b010; end
                    {7'h00, 3'b110}: begin w_legal = 1'b1; w_alu = 3'b011; end
                    {7'h00, 3'b010}: begin w_legal = 1'b1; w_alu = 3'b101; end
                    default: ;
                endcase
            end
            7'b0010011: begin
                w_src     = 1'b1;
                w_use_rd  = 1'b1;
                w_use_imm = 1'b1;
                case (w_funct3)
                    3'b000: begin w_legal = 1'b1; w_alu = 3'b000; end
                    3'b111: begin w_legal = 1'b1; w_alu = 3'b010; end
                    3'b110: begin w_legal = 1'b1; w_alu = 3'b011; end
                    3'b010: begin w_legal = 1'b1; w_alu = 3'b101; end
                    default: ;
                endcase
            end
            7'b0000011: begin
                w_legal   = (w_funct3 == 3'b010);
                w_kind    = K_LW;
                w_src     = 1'b1;
                w_use_rd  = 1'b1;
                w_use_imm = 1'b1;
            end
            7'b1100011: begin
                w_legal   = (w_funct3 == 3'b000) || (w_funct3 == 3'b001);
                w_kind    = K_BR;
                w_alu     = 3'b001;
                w_use_rs2 = 1'b1;
                w_bne     = w_funct3[0];
            end
            default: ;
        endcase
    end

    // Fields are zeroed for illegal words so nothing stale reaches the datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kind      <= K_ALU;
            r_bne       <= 1'b0;
            r_illegal   <= 1'b0;
            r_alusrc    <= 1'b0;
            r_aluctrl   <= 3'b000;
            r_imm       <= '0;
            r_boff      <= '0;
            r_resultsrc <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
        end else if (w_accept) begin
            r_kind      <= w_kind;
            r_bne       <= w_legal && w_bne;
            r_illegal   <= !w_legal;
            r_alusrc    <= w_legal && w_src;
            r_aluctrl   <= w_legal ? w_alu : 3'b000;
            r_imm       <= (w_legal && w_use_imm) ? {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]} : '0;
            r_boff      <= (w_legal && w_kind == K_BR) ?
                           {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} : '0;
            r_resultsrc <= w_legal && (w_kind == K_LW);
            r_rs1       <= w_legal ? ADDRESS_WIDTH'(instr[19:15]) : '0;
            r_rs2       <= (w_legal && w_use_rs2) ? ADDRESS_WIDTH'(instr[24:20]) : '0;
            r_rd        <= (w_legal && w_use_rd) ? ADDRESS_WIDTH'(instr[11:7]) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        RegWrite    = 1'b0;
        pc_src      = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) w_next = S_DECODE;
            end
            S_DECODE: begin
                illegal = r_illegal;
                w_next  = r_illegal ? S_IDLE : S_EXEC;
            end
            S_EXEC: begin
                if (r_kind == K_BR) begin
                    // bne takes the branch on inequality, beq on equality
                    pc_src = EQ ^ r_bne;
                    retire = 1'b1;
                    w_next = S_IDLE;
                end else if (r_kind == K_LW) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: w_next = S_WB;
            S_WB: begin
                RegWrite = (r_rd != '0);
                retire   = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign ALUsrc     = r_alusrc;
    assign ALUctrl    = r_aluctrl;
    assign immOp      = r_imm;
    assign Resultsrc  = r_resultsrc;
    assign rs1        = r_rs1;
    assign rs2        = r_rs2;
    assign rd         = r_rd;
    assign branch_off = r_boff;

`ifdef ALU_SEQ_PERF_CNT_EN
    logic [31:0] r_instret;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_instret <= '0;
        else if (retire) r_instret <= r_instret + 32'd1;
    end
    assign instret = r_instret;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Purpose : self-checking bench for alu_seq_ctrl against a mnemonic-level reference model.
// Latency : checks every cycle from handshake until the controller is ready again.
// Backpressure: instructions are offered back-to-back; instr_valid is toggled randomly while busy.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        EQ;
    logic        RegWrite, ALUsrc, Resultsrc, pc_src, retire, illegal;
    logic [2:0]  ALUctrl;
    logic [31:0] immOp, branch_off, instret;
    logic [4:0]  rs1, rs2, rd;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    localparam logic [1:0] KA = 2'd0, KL = 2'd1, KB = 2'd2;

    typedef struct packed {
        logic        legal;
        logic [1:0]  kind;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm, boff;
        logic [2:0]  alu;
        logic        src, res, bne;
    } exp_t;

    alu_seq_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .EQ(EQ), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
        .ALUctrl(ALUctrl), .immOp(immOp), .Resultsrc(Resultsrc), .rs1(rs1), .rs2(rs2),
        .rd(rd), .pc_src(pc_src), .branch_off(branch_off), .retire(retire),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: name the instruction first, then derive controls from the mnemonic
    function automatic exp_t model(input logic [31:0] w);
        exp_t  e;
        string m;
        int    b;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        e  = '0;
        m  = "";
        if (op == 7'h33) begin
            if (f7 == 7'h00 && f3 == 3'd0) m = "add";
            if (f7 == 7'h20 && f3 == 3'd0) m = "sub";
            if (f7 == 7'h00 && f3 == 3'd7) m = "and";
            if (f7 == 7'h00 && f3 == 3'd6) m = "or";
            if (f7 == 7'h00 && f3 == 3'd2) m = "slt";
        end else if (op == 7'h13) begin
            if (f3 == 3'd0) m = "addi";
            if (f3 == 3'd7) m = "andi";
            if (f3 == 3'd6) m = "ori";
            if (f3 == 3'd2) m = "slti";
        end else if (op == 7'h03 && f3 == 3'd2) begin
            m = "lw";
        end else if (op == 7'h63) begin
            if (f3 == 3'd0) m = "beq";
            if (f3 == 3'd1) m = "bne";
        end
        if (m == "") return e;
        e.legal = 1'b1;
        if (m == "add" || m == "addi" || m == "lw") e.alu = 3'b000;
        if (m == "sub" || m == "beq" || m == "bne") e.alu = 3'b001;
        if (m == "and" || m == "andi")              e.alu = 3'b010;
        if (m == "or"  || m == "ori")               e.alu = 3'b011;
        if (m == "slt" || m == "slti")              e.alu = 3'b101;
        e.kind = (m == "lw") ? KL : ((m == "beq" || m == "bne") ? KB : KA);
        e.bne  = (m == "bne");
        e.res  = (m == "lw");
        e.src  = (op == 7'h13) || (m == "lw");
        e.imm  = e.src ? 32'($signed(w) >>> 20) : 32'd0;
        e.rs1  = w[19:15];
        e.rs2  = (op == 7'h33 || e.kind == KB) ? w[24:20] : 5'd0;
        e.rd   = (e.kind == KB) ? 5'd0 : w[11:7];
        if (e.kind == KB) begin
            b = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            e.boff = 32'(b);
        end
        return e;
    endfunction

    function automatic logic [31:0] exp_instret();
`ifdef ALU_SEQ_PERF_CNT_EN
        return 32'(exp_cnt);
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk_fields(input string p, input exp_t e);
        chk({p, "_rs1"},   32'(rs1),        32'(e.rs1));
        chk({p, "_rs2"},   32'(rs2),        32'(e.rs2));
        chk({p, "_rd"},    32'(rd),         32'(e.rd));
        chk({p, "_imm"},   immOp,           e.imm);
        chk({p, "_alu"},   32'(ALUctrl),    32'(e.alu));
        chk({p, "_src"},   32'(ALUsrc),     32'(e.src));
        chk({p, "_boff"},  branch_off,      e.boff);
    endtask

    // Entered and left on a falling edge with the controller idle
    task automatic run_instr(input logic [31:0] w, input logic eq);
        exp_t e;
        int   n;
        logic take;
        e = model(w);
        n = !e.legal ? 2 : (e.kind == KB ? 3 : (e.kind == KL ? 5 : 4));
        take = e.bne ? !eq : eq;
        chk("ready_pre", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr       = w;
        EQ          = eq;
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk("ready",   32'(instr_ready), 32'(k == n));
            chk("regwr",   32'(RegWrite),    32'(e.legal && e.kind != KB && k == n - 1 && e.rd != 5'd0));
            chk("retire",  32'(retire),      32'(e.legal && k == n - 1));
            chk("pc_src",  32'(pc_src),      32'(e.legal && e.kind == KB && k == 2 && take));
            chk("illegal", 32'(illegal),     32'(!e.legal && k == 1));
            chk("ressrc",  32'(Resultsrc),   32'(e.res));
            if (k == 1) chk_fields("dec", e);
            if (k == n) begin
                chk_fields("held", e);
                if (e.legal) exp_cnt++;
                chk("instret", instret, exp_instret());
                instr_valid = 1'b0;
            end else begin
                instr_valid = 1'($urandom);
                instr       = $urandom;
            end
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        logic [2:0]  f3s;
        w = $urandom;
        case ($urandom_range(0, 4))
            0: begin
                w[6:0] = 7'h33;
                f3s = 3'($urandom_range(0, 3));
                w[14:12] = (f3s == 3'd0) ? 3'd0 : (f3s == 3'd1) ? 3'd7 : (f3s == 3'd2) ? 3'd6 : 3'd2;
                w[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
            end
            1: w[6:0] = 7'h13;
            2: begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
            3: begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(0, 1)); end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 32'd0;
        EQ = 1'b0;
        #1;
        chk("rst_ready",  32'(instr_ready), 32'd1);
        chk("rst_regwr",  32'(RegWrite),    32'd0);
        chk("rst_src",    32'(ALUsrc),      32'd0);
        chk("rst_alu",    32'(ALUctrl),     32'd0);
        chk("rst_imm",    immOp,            32'd0);
        chk("rst_res",    32'(Resultsrc),   32'd0);
        chk("rst_rs1",    32'(rs1),         32'd0);
        chk("rst_rs2",    32'(rs2),         32'd0);
        chk("rst_rd",     32'(rd),          32'd0);
        chk("rst_pc",     32'(pc_src),      32'd0);
        chk("rst_boff",   branch_off,       32'd0);
        chk("rst_retire", 32'(retire),      32'd0);
        chk("rst_ill",    32'(illegal),     32'd0);
        chk("rst_cnt",    instret,          32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_instr(32'h00500093, 1'b0);   // addi x1,x0,5
        run_instr(32'h402081B3, 1'b0);   // sub x3,x1,x2
        run_instr(32'h0040A283, 1'b0);   // lw x5,4(x1)
        run_instr(32'h00209463, 1'b0);   // bne taken
        run_instr(32'h00209463, 1'b1);   // bne not taken
        run_instr(32'h00208463, 1'b1);   // beq taken
        run_instr(32'h00100013, 1'b0);   // addi x0,x0,1
        run_instr(32'h0000007F, 1'b0);   // illegal opcode
        run_instr(32'hFE208EE3, 1'b1);   // beq backwards

        for (int i = 0; i < 40; i++) run_instr(rnd_instr(), 1'($urandom));

        // Reset during EXEC of an add abandons it without a register write
        instr_valid = 1'b1;
        instr = 32'h002081B3;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = 0;
        #1;
        chk("mrst_ready", 32'(instr_ready), 32'd1);
        chk("mrst_regwr", 32'(RegWrite),    32'd0);
        chk("mrst_rd",    32'(rd),          32'd0);
        chk("mrst_alu",   32'(ALUctrl),     32'd0);
        chk("mrst_retire",32'(retire),      32'd0);
        chk("mrst_cnt",   instret,          32'd0);
        @(negedge clk);
        chk("mrst_regwr2", 32'(RegWrite),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_regwr", 32'(RegWrite),    32'd0);
        chk("post_cnt",   instret,          32'd0);
        run_instr(32'h00500093, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
